// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Hazard controller for a 5-stage in-order pipeline. It produces
//            Mealy (same-cycle) stall, flush and bubble controls for load-use
//            hazards, taken branches, jumps and data-memory waits. It also
//            keeps statistics counters and a sticky memory-wait timeout flag.
// Ports    :
//   clk               in   1  rising-edge clock
//   clrn              in   1  asynchronous active-low reset
//   load_depen        in   1  ID instruction depends on a load in EXE
//   exe_condition_jmp in   1  conditional branch in EXE
//   btaken            in   1  branch condition resolved true
//   id_jump           in   1  unconditional jump decoded in ID
//   mem_busy          in   1  data memory not ready (freeze pipeline)
//   clr_stats         in   1  synchronous clear of stall_cnt / flush_cnt
//   pc_we             out  1  PC write enable
//   ifid_we           out  1  IF/ID write enable
//   ifid_flush        out  1  load NOP into IF/ID
//   idexe_bubble      out  1  load NOP into ID/EXE
//   pipe_hold         out  1  freeze EXE/MEM/WB registers
//   state             out  2  FSM state (00 RUN, 01 LSTALL, 10 MWAIT)
//   stall_cnt         out 16  load-use stall cycles (wraps)
//   flush_cnt         out 16  squashed instruction slots (wraps)
//   timeout           out  1  sticky memory-wait overrun flag
// Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        clrn,
  input  logic        load_depen,
  input  logic        exe_condition_jmp,
  input  logic        btaken,
  input  logic        id_jump,
  input  logic        mem_busy,
  input  logic        clr_stats,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idexe_bubble,
  output logic        pipe_hold,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic        timeout
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    LSTALL = 2'b01,
    MWAIT  = 2'b10
  } state_t;

  localparam logic [7:0] c_WAIT_MAX = 8'd255;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_wait_cnt;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;
  logic        r_timeout;

  logic        w_br_taken;
  logic        w_stall_inc;
  logic [1:0]  w_flush_inc;
  logic        w_wait_load;
  logic        w_wait_inc;

  assign w_br_taken = exe_condition_jmp & btaken;

  // --------------------------------------------------------------------------
  // Next-state and Mealy outputs. Defaults are the "no event" RUN behaviour,
  // which also covers the unreachable 2'b11 encoding.
  // --------------------------------------------------------------------------
  always_comb begin
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    ifid_flush   = 1'b0;
    idexe_bubble = 1'b0;
    pipe_hold    = 1'b0;
    w_state_nxt  = RUN;
    w_stall_inc  = 1'b0;
    w_flush_inc  = 2'd0;
    w_wait_load  = 1'b0;
    w_wait_inc   = 1'b0;

    case (r_state)
      RUN, LSTALL, MWAIT: begin
        if (r_state == MWAIT && mem_busy) begin
          // Still waiting: branches and hazards are ignored until memory is ready.
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          pipe_hold   = 1'b1;
          w_state_nxt = MWAIT;
          w_wait_inc  = 1'b1;
        end else if (w_br_taken) begin
          // Squash both younger slots (IF/ID and ID/EXE).
          ifid_flush   = 1'b1;
          idexe_bubble = 1'b1;
          w_flush_inc  = 2'd2;
        end else if (mem_busy) begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          pipe_hold   = 1'b1;
          w_state_nxt = MWAIT;
          w_wait_load = 1'b1;
        end else if (load_depen && r_state != LSTALL) begin
          // LSTALL is only one cycle long, so a held load_depen is not re-stalled.
          pc_we        = 1'b0;
          ifid_we      = 1'b0;
          idexe_bubble = 1'b1;
          w_state_nxt  = LSTALL;
          w_stall_inc  = 1'b1;
        end else if (id_jump) begin
          ifid_flush  = 1'b1;
          w_flush_inc = 2'd1;
        end
      end
      default: ;
    endcase

    // Reset forces a safe NOP-injecting pattern regardless of other inputs.
    if (!clrn) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      ifid_flush   = 1'b1;
      idexe_bubble = 1'b1;
      pipe_hold    = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // State, wait counter and sticky timeout
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state    <= RUN;
      r_wait_cnt <= 8'd0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wait_load) begin
        r_wait_cnt <= 8'd1;
      end else if (w_wait_inc && r_wait_cnt != c_WAIT_MAX) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end
      // Set on the same edge the counter arrives at (or sits at) its maximum.
      if (w_wait_inc && r_wait_cnt >= (c_WAIT_MAX - 8'd1)) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Statistics counters; clear has priority over increments
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else if (clr_stats) begin
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      r_stall_cnt <= r_stall_cnt + {15'd0, w_stall_inc};
      r_flush_cnt <= r_flush_cnt + {14'd0, w_flush_inc};
    end
  end

  assign state     = r_state;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
  assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Self-checking bench for pipe_hazard_ctrl. Directed scenarios
//            followed by randomized traffic. Expected values come from a
//            behavioural model built directly from the event priority rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        clrn;
  logic        load_depen, exe_condition_jmp, btaken, id_jump, mem_busy, clr_stats;
  logic        pc_we, ifid_we, ifid_flush, idexe_bubble, pipe_hold;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;
  logic        timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: mode 0=RUN, 1=LSTALL, 2=MWAIT
  int m_mode, m_wait, m_stall, m_flush;
  bit m_tmo;

  pipe_hazard_ctrl u_dut (
    .clk               (clk),
    .clrn              (clrn),
    .load_depen        (load_depen),
    .exe_condition_jmp (exe_condition_jmp),
    .btaken            (btaken),
    .id_jump           (id_jump),
    .mem_busy          (mem_busy),
    .clr_stats         (clr_stats),
    .pc_we             (pc_we),
    .ifid_we           (ifid_we),
    .ifid_flush        (ifid_flush),
    .idexe_bubble      (idexe_bubble),
    .pipe_hold         (pipe_hold),
    .state             (state),
    .stall_cnt         (stall_cnt),
    .flush_cnt         (flush_cnt),
    .timeout           (timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs after the falling edge, check the Mealy
  // outputs and registered state before the rising edge, then advance the model.
  task automatic step(input bit rn, input bit ld, input bit cj, input bit bt,
                      input bit jmp, input bit mb, input bit clr);
    int nm, nw, ns, nf;
    bit nt;
    logic [4:0] eo;
    @(negedge clk);
    clrn = rn; load_depen = ld; exe_condition_jmp = cj; btaken = bt;
    id_jump = jmp; mem_busy = mb; clr_stats = clr;
    if (!rn) begin
      m_mode = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_tmo = 0;
    end
    #1;
    nm = 0; nw = m_wait; ns = m_stall; nf = m_flush; nt = m_tmo;
    // eo = {pc_we, ifid_we, ifid_flush, idexe_bubble, pipe_hold}
    if (!rn) begin
      eo = 5'b00110;
    end else if (m_mode == 2 && mb) begin
      eo = 5'b00001; nm = 2;
      nw = (m_wait < 255) ? m_wait + 1 : 255;
      if (nw == 255) nt = 1;
    end else if (cj && bt) begin
      eo = 5'b11110; nf = m_flush + 2;
    end else if (mb) begin
      eo = 5'b00001; nm = 2; nw = 1;
    end else if (ld && m_mode != 1) begin
      eo = 5'b00010; nm = 1; ns = m_stall + 1;
    end else if (jmp) begin
      eo = 5'b11100; nf = m_flush + 1;
    end else begin
      eo = 5'b11000;
    end
    if (clr) begin ns = 0; nf = 0; end
    ns = ns % 65536;
    nf = nf % 65536;

    check_eq("ctrl_outs", {27'd0, pc_we, ifid_we, ifid_flush, idexe_bubble, pipe_hold}, {27'd0, eo});
    check_eq("state",     {30'd0, state},     32'(m_mode));
    check_eq("stall_cnt", {16'd0, stall_cnt}, 32'(m_stall));
    check_eq("flush_cnt", {16'd0, flush_cnt}, 32'(m_flush));
    check_eq("timeout",   {31'd0, timeout},   {31'd0, m_tmo});

    @(posedge clk);
    if (rn) begin
      m_mode = nm; m_wait = nw; m_stall = ns; m_flush = nf; m_tmo = nt;
    end
    #1;
  endtask

  initial begin
    clrn = 1'b0; load_depen = 0; exe_condition_jmp = 0; btaken = 0;
    id_jump = 0; mem_busy = 0; clr_stats = 0;
    m_mode = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_tmo = 0;

    // args: rn, ld, cj, bt, jmp, mb, clr
    repeat (2) step(0, 1, 1, 1, 1, 1, 0);

    // Load-use stall: one bubble, one LSTALL cycle, then normal flow
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check_eq("lduse_stall_cnt", {16'd0, stall_cnt}, 32'd1);

    // Taken branch beats a simultaneous load dependency
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check_eq("br_flush_cnt", {16'd0, flush_cnt}, 32'd2);
    check_eq("br_stall_cnt", {16'd0, stall_cnt}, 32'd0);

    // Five-cycle memory wait, then release
    repeat (5) step(1, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check_eq("mwait5_state", {30'd0, state}, 32'd0);
    check_eq("mwait5_tmo",   {31'd0, timeout}, 32'd0);

    // Branch and load hazard arriving while memory is still busy are ignored
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 1, 1, 1, 1, 1, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);

    // Long memory wait: timeout sets and stays sticky, even across clr_stats
    repeat (300) step(1, 0, 0, 0, 0, 1, 0);
    repeat (3) step(1, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    check_eq("tmo_sticky", {31'd0, timeout}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 0);
    check_eq("tmo_reset", {31'd0, timeout}, 32'd0);

    // Reset asserted in the middle of a memory wait and a load stall
    repeat (4) step(1, 0, 0, 0, 0, 1, 0);
    step(0, 1, 1, 1, 1, 1, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);

    // Randomized traffic with occasional reset and clear
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) != 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 39) == 0);
    end

    // Counter wrap: 65537 jump slots leave flush_cnt at 1
    step(1, 0, 0, 0, 0, 0, 1);
    repeat (65537) step(1, 0, 0, 0, 1, 0, 0);
    check_eq("wrap_flush_cnt", {16'd0, flush_cnt}, 32'd1);
    step(1, 0, 0, 0, 1, 0, 1);
    check_eq("clr_wins_flush", {16'd0, flush_cnt}, 32'd0);
    step(1, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
